// File: rtl/cdt_pkg.sv
// Shared types and constants for the minute:second countdown engine.
package cdt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } cdt_state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t m;
    bcd_t s10;
    bcd_t s1;
  } mss_t;

  localparam int LED_RUN   = 0;
  localparam int LED_PAUSE = 1;
  localparam int LED_ALARM = 2;

  // Counter width for a divider of n states; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdt_if.sv
// Button/switch inputs and display/buzzer outputs of the countdown engine.
interface cdt_if;
  logic [3:0] PSW;
  logic [3:0] RSW;
  logic [3:0] DIG_M;
  logic [3:0] DIG_S10;
  logic [3:0] DIG_S1;
  logic [7:0] LED;
  logic       BZ;

  modport master (
    output PSW, RSW,
    input  DIG_M, DIG_S10, DIG_S1, LED, BZ
  );

  modport slave (
    input  PSW, RSW,
    output DIG_M, DIG_S10, DIG_S1, LED, BZ
  );
endinterface

// File: rtl/cdt_prescaler.sv
// Free-running divider with enable/clear; tick is high on the last count while enabled.
module cdt_prescaler
  import cdt_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = cnt_w(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/countdown_core.sv
// M:SS countdown engine: preset from rotary switch, start/pause and stop buttons, alarm at 0:00.
// Define CDT_BEEP_PATTERN_EN to pulse the buzzer every BZ_DIV cycles instead of driving it steadily.
module countdown_core
  import cdt_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int BZ_DIV   = 250
) (
  input  logic  CLOCK,
  input  logic  RESET,
  cdt_if.slave  io
);

  if (TICK_DIV < 1 || BZ_DIV < 1) begin : g_param_check
    $error("countdown_core: TICK_DIV and BZ_DIV must be >= 1");
  end

  cdt_state_t state_q, state_d;
  mss_t       dig_q, dig_d, dec;
  logic [1:0] psw_p1;
  logic [7:0] led_q, led_d;
  logic       bz_q, bz_d;
  logic       tick, start_p, stop_p;
  bcd_t       rsw_min;
  logic       unused_psw;

  assign unused_psw = ^io.PSW[3:2];

  // Stop wins over a coincident start press.
  assign stop_p  = io.PSW[1] & ~psw_p1[1];
  assign start_p = io.PSW[0] & ~psw_p1[0] & ~stop_p;
  assign rsw_min = (io.RSW > 4'd9) ? 4'd9 : io.RSW;

  function automatic mss_t bcd_dec(input mss_t v);
    mss_t r;
    r = v;
    if (v.s1 != 4'd0) begin
      r.s1 = v.s1 - 4'd1;
    end else begin
      r.s1 = 4'd9;
      if (v.s10 != 4'd0) begin
        r.s10 = v.s10 - 4'd1;
      end else begin
        r.s10 = 4'd5;
        r.m   = (v.m != 4'd0) ? v.m - 4'd1 : 4'd9;
      end
    end
    return r;
  endfunction

  function automatic logic is_zero(input mss_t v);
    return (v.m == 4'd0) && (v.s10 == 4'd0) && (v.s1 == 4'd0);
  endfunction

  cdt_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (CLOCK),
    .rst  (RESET),
    .en   (state_q == RUN),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

`ifdef CDT_BEEP_PATTERN_EN
  logic beep_tick;

  cdt_prescaler #(.TICK_DIV(BZ_DIV)) u_beep (
    .clk  (CLOCK),
    .rst  (RESET),
    .en   (state_q == ALARM),
    .clr  (state_q != ALARM),
    .tick (beep_tick)
  );
`endif

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    led_d   = '0;
    bz_d    = 1'b0;
    dec     = bcd_dec(dig_q);
    case (state_q)
      IDLE: begin
        dig_d.m   = rsw_min;
        dig_d.s10 = 4'd0;
        dig_d.s1  = 4'd0;
        if (start_p && (rsw_min != 4'd0)) state_d = RUN;
      end
      RUN: begin
        if (stop_p) begin
          state_d = IDLE;
        end else if (tick) begin
          dig_d = dec;
          if (is_zero(dec))  state_d = ALARM;
          else if (start_p)  state_d = PAUSE;
        end else if (start_p) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (stop_p)       state_d = IDLE;
        else if (start_p) state_d = RUN;
      end
      ALARM: begin
        dig_d = '0;
        if (stop_p) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs decode the next state so they update on the same edge as the state.
    led_d[LED_RUN]   = (state_d == RUN);
    led_d[LED_PAUSE] = (state_d == PAUSE);
    led_d[LED_ALARM] = (state_d == ALARM);
`ifdef CDT_BEEP_PATTERN_EN
    if (state_d == ALARM) begin
      if (state_q != ALARM) bz_d = 1'b1;
      else                  bz_d = beep_tick ? ~bz_q : bz_q;
    end
`else
    bz_d = (state_d == ALARM);
`endif
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      psw_p1  <= '0;
      dig_q   <= '0;
      led_q   <= '0;
      bz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      psw_p1  <= io.PSW[1:0];
      dig_q   <= dig_d;
      led_q   <= led_d;
      bz_q    <= bz_d;
    end
  end

  assign io.DIG_M   = dig_q.m;
  assign io.DIG_S10 = dig_q.s10;
  assign io.DIG_S1  = dig_q.s1;
  assign io.LED     = led_q;
  assign io.BZ      = bz_q;

endmodule

// File: tb/tb_countdown_core.sv
// Scoreboard bench for countdown_core: stimulus queues expected outputs by cycle, a monitor compares them.
module tb_countdown_core;
  localparam int TICK_DIV = 2;
  localparam int BZ_DIV   = 3;

  logic CLOCK;
  logic RESET;
  int   cyc;
  int   checks;
  int   failures;

  cdt_if bus();

  countdown_core #(.TICK_DIV(TICK_DIV), .BZ_DIV(BZ_DIV)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .io    (bus)
  );

  typedef struct {
    int         at;
    string      name;
    logic [3:0] m;
    logic [3:0] s10;
    logic [3:0] s1;
    logic [7:0] led;
    logic       bz;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  always @(posedge CLOCK) cyc <= cyc + 1;

  always @(negedge CLOCK) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      checks = checks + 1;
      if ({bus.DIG_M, bus.DIG_S10, bus.DIG_S1, bus.LED, bus.BZ} !==
          {cur.m, cur.s10, cur.s1, cur.led, cur.bz}) begin
        failures = failures + 1;
        $display("FAIL %s @cyc %0d: got %h:%h%h led=%b bz=%b, required %h:%h%h led=%b bz=%b",
                 cur.name, cyc, bus.DIG_M, bus.DIG_S10, bus.DIG_S1, bus.LED, bus.BZ,
                 cur.m, cur.s10, cur.s1, cur.led, cur.bz);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic expect_at(input int n, input string nm, input logic [3:0] m,
                           input logic [3:0] s10, input logic [3:0] s1,
                           input logic [7:0] led, input logic bz);
    exp_t e;
    e.at = cyc + n; e.name = nm; e.m = m; e.s10 = s10; e.s1 = s1; e.led = led; e.bz = bz;
    sb.push_back(e);
  endtask

  // k = clock edges since ALARM entry.
  function automatic logic bz_exp(input int k);
`ifdef CDT_BEEP_PATTERN_EN
    return ((k / BZ_DIV) % 2) == 0;
`else
    return (k >= 0);
`endif
  endfunction

  initial begin
    cyc = 0; checks = 0; failures = 0;
    RESET = 1'b1; bus.PSW = 4'd0; bus.RSW = 4'd1;
    step(2);
    expect_at(1, "reset_state", 4'd0, 4'd0, 4'd0, 8'h00, 1'b0);
    step(1);
    RESET = 1'b0;
    expect_at(1, "idle_preset", 4'd1, 4'd0, 4'd0, 8'h00, 1'b0);
    step(1);
    bus.RSW = 4'd12;
    expect_at(1, "rsw_clamp", 4'd9, 4'd0, 4'd0, 8'h00, 1'b0);
    step(1);

    // Start from 1:00, two ticks, then pause on a non-tick cycle
    bus.RSW = 4'd1; bus.PSW = 4'd1;
    expect_at(1, "run_start", 4'd1, 4'd0, 4'd0, 8'h01, 1'b0);
    step(1);
    bus.PSW = 4'd0;
    expect_at(4, "two_ticks", 4'd0, 4'd5, 4'd8, 8'h01, 1'b0);
    step(4);
    bus.PSW = 4'd1;
    expect_at(1, "pause", 4'd0, 4'd5, 4'd8, 8'h02, 1'b0);
    step(1);
    bus.PSW = 4'd0;
    expect_at(10, "pause_hold10", 4'd0, 4'd5, 4'd8, 8'h02, 1'b0);
    expect_at(20, "pause_hold20", 4'd0, 4'd5, 4'd8, 8'h02, 1'b0);
    step(20);
    bus.PSW = 4'd1;
    expect_at(1, "resume", 4'd0, 4'd5, 4'd8, 8'h01, 1'b0);
    expect_at(2, "resume_tick", 4'd0, 4'd5, 4'd7, 8'h01, 1'b0);
    step(1);
    bus.PSW = 4'd0;
    expect_at(15, "at_0_50", 4'd0, 4'd5, 4'd0, 8'h01, 1'b0);
    expect_at(17, "borrow_s10", 4'd0, 4'd4, 4'd9, 8'h01, 1'b0);
    expect_at(114, "pre_alarm", 4'd0, 4'd0, 4'd1, 8'h01, 1'b0);
    expect_at(115, "alarm_entry", 4'd0, 4'd0, 4'd0, 8'h04, 1'b1);
    step(115);
    for (int k = 1; k <= 6; k++) expect_at(k, "alarm_bz", 4'd0, 4'd0, 4'd0, 8'h04, bz_exp(k));
    step(7);

    // ALARM: start ignored, stop clears
    bus.PSW = 4'd1;
    expect_at(1, "alarm_ign_start", 4'd0, 4'd0, 4'd0, 8'h04, bz_exp(8));
    step(1);
    bus.PSW = 4'd0;
    step(1);
    bus.PSW = 4'd2;
    expect_at(1, "alarm_stop", 4'd0, 4'd0, 4'd0, 8'h00, 1'b0);
    step(1);
    bus.PSW = 4'd0; bus.RSW = 4'd2;
    expect_at(1, "idle_rsw2", 4'd2, 4'd0, 4'd0, 8'h00, 1'b0);
    step(1);
    bus.PSW = 4'd1;
    expect_at(1, "run_2_00", 4'd2, 4'd0, 4'd0, 8'h01, 1'b0);
    step(1);
    bus.PSW = 4'd0;
    expect_at(2, "borrow_m", 4'd1, 4'd5, 4'd9, 8'h01, 1'b0);
    step(2);

    // Both buttons together, then held: stop wins and nothing repeats
    bus.PSW = 4'd3;
    expect_at(2, "both_stop", 4'd2, 4'd0, 4'd0, 8'h00, 1'b0);
    expect_at(11, "both_held", 4'd2, 4'd0, 4'd0, 8'h00, 1'b0);
    step(10);
    bus.PSW = 4'd0;
    step(1);
    bus.PSW = 4'd1;
    expect_at(1, "start_hold", 4'd2, 4'd0, 4'd0, 8'h01, 1'b0);
    expect_at(10, "start_held_run", 4'd1, 4'd5, 4'd6, 8'h01, 1'b0);
    step(10);
    bus.PSW = 4'd0;

    // Reset mid-run, then a start with RSW=0 must not run
    RESET = 1'b1;
    expect_at(1, "reset_mid_run", 4'd0, 4'd0, 4'd0, 8'h00, 1'b0);
    step(1);
    RESET = 1'b0;
    expect_at(1, "post_reset_idle", 4'd2, 4'd0, 4'd0, 8'h00, 1'b0);
    step(1);
    bus.RSW = 4'd0;
    step(1);
    bus.PSW = 4'd1;
    expect_at(1, "rsw0_no_start", 4'd0, 4'd0, 4'd0, 8'h00, 1'b0);
    step(1);
    bus.PSW = 4'd0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
    if (sb.size() != 0) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
